uart_tx: RTL and testbench

Serial UART transmitter that consumes the single-cycle baud tick from the baud generator and serialises one parallel byte per frame onto the tx line. Format is start bit, DATA_BITS data bits (LSB first), optional parity bit, then STOP_BITS stop bits. Parallel data is accepted from the host side through a valid/ready handshake. The block sits between the host/register interface and the UART pin, as a peer of the baud generator.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx.sv | 131 +++++++++++++
 tb/tb_uart_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state codes, parity modes
// and the parity helper used when a byte is latched.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Unused high bits must be zero so they do not disturb the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bits,
// paced by an external one-clock baud tick.
//
// state  | meaning
// IDLE   | line high, ready for a byte
// SYNC   | byte latched, waiting for a tick to align the start bit
// START  | start bit (low) on the line
// DATA   | data bits, LSB first
// PARITY | parity bit on the line
// STOP   | stop bit(s), line high
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in 5..8");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  logic [2:0]           state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_cnt;
  logic                 par_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_valid && tx_ready) begin
            shift    <= tx_data;
            par_bit  <= parity_bit(8'(tx_data), PARITY);
            state    <= ST_SYNC;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        ST_SYNC: begin
          if (baud_tick) begin
            state <= ST_START;
            tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            state   <= ST_DATA;
            tx      <= shift[0];
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            shift <= shift >> 1;
            if (bit_cnt == LAST_DATA) begin
              // Counter is reused for the stop bits.
              bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (baud_tick) begin
            state   <= ST_STOP;
            tx      <= 1'b1;
            bit_cnt <= '0;
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_STOP) begin
              state    <= ST_IDLE;
              bit_cnt  <= '0;
              tx_done  <= 1'b1;
              tx_busy  <= 1'b0;
              tx_ready <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameterisations (8N1, 8E1, 8O1, 7N2)
// sharing clock, reset, baud tick and data; frames checked bit by bit.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       baud_tick;
  logic       tick_en;
  logic [7:0] tx_data;
  logic [3:0] tx_valid;
  logic [3:0] tx_w, ready_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;
  int done_cnt[4] = '{0, 0, 0, 0};
  int ph = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid[0]), .tx_ready(ready_w[0]), .tx(tx_w[0]),
    .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid[1]), .tx_ready(ready_w[1]), .tx(tx_w[1]),
    .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid[2]), .tx_ready(ready_w[2]), .tx(tx_w[2]),
    .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  uart_tx #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(tx_data[6:0]),
    .tx_valid(tx_valid[3]), .tx_ready(ready_w[3]), .tx(tx_w[3]),
    .tx_busy(busy_w[3]), .tx_done(done_w[3]));

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;

  // One-clock tick every 4 clocks; can be stalled via tick_en.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        ph = (ph + 1) % 4;
        baud_tick = (ph == 0);
      end else begin
        baud_tick = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] d);
    tx_data = d;
    tx_valid[idx] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!ready_w[idx]) break;
    end
    tx_valid[idx] = 1'b0;
    chk($sformatf("accept_ready_%0d", idx), 32'(ready_w[idx]), 32'd0);
    chk($sformatf("accept_busy_%0d", idx), 32'(busy_w[idx]), 32'd1);
  endtask

  task automatic wait_start(input int idx, output int highs);
    bit found;
    found = 1'b0;
    highs = 0;
    for (int n = 0; n < 200; n++) begin
      if (tx_w[idx] === 1'b0) begin
        found = 1'b1;
        break;
      end
      highs++;
      @(negedge clk);
    end
    chk($sformatf("start_seen_%0d", idx), 32'(found), 32'd1);
  endtask

  // frame[i] is the i-th bit on the line; each level must hold 4 clocks.
  task automatic check_frame(input string tag, input int idx, input logic [15:0] frame,
                             input int nbits, output int highs);
    wait_start(idx, highs);
    for (int i = 0; i < nbits; i++) begin
      chk($sformatf("%s_b%0d_early", tag, i), 32'(tx_w[idx]), 32'(frame[i]));
      chk($sformatf("%s_b%0d_busy", tag, i), 32'(busy_w[idx]), 32'd1);
      repeat (3) @(negedge clk);
      chk($sformatf("%s_b%0d_late", tag, i), 32'(tx_w[idx]), 32'(frame[i]));
      chk($sformatf("%s_b%0d_nodone", tag, i), 32'(done_w[idx]), 32'd0);
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(done_w[idx]), 32'd1);
    chk({tag, "_ready_end"}, 32'(ready_w[idx]), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy_w[idx]), 32'd0);
    chk({tag, "_idle_tx"}, 32'(tx_w[idx]), 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done_w[idx]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs, d0, lows;
    reset_n  = 1'b0;
    tick_en  = 1'b1;
    tx_valid = 4'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx_%0d", i), 32'(tx_w[i]), 32'd1);
      chk($sformatf("rst_ready_%0d", i), 32'(ready_w[i]), 32'd1);
      chk($sformatf("rst_busy_%0d", i), 32'(busy_w[i]), 32'd0);
      chk($sformatf("rst_done_%0d", i), 32'(done_w[i]), 32'd0);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0x55, with the tick stalled while in SYNC
    d0 = done_cnt[0];
    send(0, 8'h55);
    #1 tick_en = 1'b0;
    baud_tick = 1'b0;
    repeat (20) @(negedge clk);
    chk("stall_tx", 32'(tx_w[0]), 32'd1);
    chk("stall_busy", 32'(busy_w[0]), 32'd1);
    chk("stall_ready", 32'(ready_w[0]), 32'd0);
    #1 tick_en = 1'b1;
    @(negedge clk);
    check_frame("8n1_55", 0, {6'b0, 1'b1, 8'h55, 1'b0}, 10, highs);
    repeat (5) @(negedge clk);
    chk("8n1_done_count", 32'(done_cnt[0] - d0), 32'd1);

    // 0xA3 has four ones: even parity 0, odd parity 1
    send(1, 8'hA3);
    check_frame("8e1_a3", 1, {5'b0, 1'b1, 1'b0, 8'hA3, 1'b0}, 11, highs);
    send(2, 8'hA3);
    check_frame("8o1_a3", 2, {5'b0, 1'b1, 1'b1, 8'hA3, 1'b0}, 11, highs);

    // 7 data bits, 2 stop bits
    d0 = done_cnt[3];
    send(3, 8'h7F);
    check_frame("7n2_7f", 3, {6'b0, 2'b11, 7'h7F, 1'b0}, 10, highs);
    repeat (5) @(negedge clk);
    chk("7n2_done_count", 32'(done_cnt[3] - d0), 32'd1);

    // Back-to-back: second byte accepted on the tx_done cycle
    repeat (4) @(negedge clk);
    d0 = done_cnt[0];
    tx_data = 8'h01;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    chk("b2b_first_accept", 32'(ready_w[0]), 32'd0);
    tx_data = 8'h80;
    check_frame("b2b_first", 0, {6'b0, 1'b1, 8'h01, 1'b0}, 10, highs);
    chk("b2b_accept_on_done", 32'(ready_w[0]), 32'd0);
    chk("b2b_busy_again", 32'(busy_w[0]), 32'd1);
    tx_valid[0] = 1'b0;
    check_frame("b2b_second", 0, {6'b0, 1'b1, 8'h80, 1'b0}, 10, highs);
    chk("b2b_gap", 32'(highs), 32'd3);
    repeat (5) @(negedge clk);
    chk("b2b_done_count", 32'(done_cnt[0] - d0), 32'd2);

    // tx_valid pulsed while busy must be ignored
    repeat (4) @(negedge clk);
    d0 = done_cnt[0];
    send(0, 8'h0F);
    fork
      check_frame("busy_ignore", 0, {6'b0, 1'b1, 8'h0F, 1'b0}, 10, highs);
      begin
        repeat (12) @(negedge clk);
        tx_data = 8'hFF;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
      end
    join
    lows = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_w[0] === 1'b0) lows++;
    end
    chk("ignore_no_second_frame", 32'(lows), 32'd0);
    chk("ignore_done_count", 32'(done_cnt[0] - d0), 32'd1);
    chk("ignore_busy", 32'(busy_w[0]), 32'd0);

    // Reset during data bit 3 of 0xA5 (bit 3 = 0)
    send(0, 8'hA5);
    wait_start(0, highs);
    repeat (16) @(negedge clk);
    chk("rst_pre_d3", 32'(tx_w[0]), 32'd0);
    @(negedge clk);
    d0 = done_cnt[0];
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async_tx", 32'(tx_w[0]), 32'd1);
    chk("rst_async_ready", 32'(ready_w[0]), 32'd1);
    chk("rst_async_busy", 32'(busy_w[0]), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt[0] - d0), 32'd0);
    send(0, 8'h3C);
    check_frame("after_rst_3c", 0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, highs);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
